// File: rtl/param_demux_reg.sv
// Registered 1-to-X_to_1 write demultiplexer with byte-lane strobes and per-register storage.
// Every stored word is exposed on o_demux; o_valid/o_err pulse one cycle after each request.
module param_demux_reg #(
    parameter int input_length = 32,
    parameter int X_to_1       = 32,
    parameter int ZERO_REG     = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en_demux,
    input  logic                        clr,
    input  logic [input_length-1:0]     i_demux,
    input  logic [$clog2(X_to_1)-1:0]   select,
    input  logic [input_length/8-1:0]   byte_en,
    output logic [input_length-1:0]     o_demux [X_to_1],
    output logic [X_to_1-1:0]           o_valid,
    output logic                        o_err
);

    localparam int SEL_W = $clog2(X_to_1);
    localparam int NB    = input_length / 8;

    typedef enum logic [1:0] {
        REQ_IDLE,
        REQ_ACCEPT,
        REQ_REJECT,
        REQ_CLEAR
    } req_t;

    logic              sel_in_range;
    logic              zero_hit;
    logic              accept;
    req_t              req_kind;
    logic [X_to_1-1:0] valid_next;

    // With a power-of-two register count every select value names a real register.
    generate
        if (X_to_1 == (1 << SEL_W)) begin : g_range_full
            assign sel_in_range = 1'b1;
        end else begin : g_range_partial
            assign sel_in_range = (select < SEL_W'(X_to_1));
        end
    endgenerate

    assign zero_hit = (ZERO_REG != 0) && (select == '0);

    always_comb begin
        req_kind = REQ_IDLE;
        if (clr) begin
            req_kind = REQ_CLEAR;
        end else if (en_demux) begin
            if (sel_in_range && !zero_hit) begin
                req_kind = REQ_ACCEPT;
            end else begin
                req_kind = REQ_REJECT;
            end
        end
    end

    assign accept = (req_kind == REQ_ACCEPT);

    always_comb begin
        valid_next = '0;
        for (int i = 0; i < X_to_1; i++) begin
            if (accept && (select == SEL_W'(i))) begin
                valid_next[i] = 1'b1;
            end
        end
    end

    // Register 0 may be a constant zero; all others are byte-writable flops.
    generate
        for (genvar i = 0; i < X_to_1; i++) begin : g_reg
            if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
                assign o_demux[i] = '0;
            end else begin : g_store
                logic [input_length-1:0] word;
                logic [NB-1:0]           lane_we;

                assign lane_we = (accept && (select == SEL_W'(i))) ? byte_en : '0;

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        word <= '0;
                    end else if (clr) begin
                        word <= '0;
                    end else begin
                        for (int k = 0; k < NB; k++) begin
                            if (lane_we[k]) begin
                                word[8*k +: 8] <= i_demux[8*k +: 8];
                            end
                        end
                    end
                end

                assign o_demux[i] = word;
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid <= '0;
            o_err   <= 1'b0;
        end else begin
            o_valid <= valid_next;
            o_err   <= (req_kind == REQ_REJECT);
        end
    end

endmodule

// File: tb/tb_param_demux_reg.sv
// Directed bench for param_demux_reg: default build, a writable-register-0 build,
// and a non-power-of-two build (5 registers).
module tb_param_demux_reg;

    typedef struct {
        logic        en;
        logic        clr;
        logic [4:0]  sel;
        logic [31:0] din;
        logic [3:0]  be;
        int          idx;
        logic [31:0] exp_word;
        logic [31:0] exp_valid;
        logic        exp_err;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        clr;
    logic [31:0] din;
    logic [3:0]  be;

    logic        en_a;
    logic [4:0]  sel_a;
    logic [31:0] oa [32];
    logic [31:0] va;
    logic        ea;

    logic        en_b;
    logic [4:0]  sel_b;
    logic [31:0] ob [32];
    logic [31:0] vb;
    logic        eb;

    logic        en_c;
    logic [2:0]  sel_c;
    logic [31:0] oc [5];
    logic [4:0]  vc;
    logic        ec;

    int total;
    int bad;
    vec_t vecs [15];

    param_demux_reg #(.input_length(32), .X_to_1(32), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst(rst), .en_demux(en_a), .clr(clr), .i_demux(din),
        .select(sel_a), .byte_en(be), .o_demux(oa), .o_valid(va), .o_err(ea)
    );

    param_demux_reg #(.input_length(32), .X_to_1(32), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst(rst), .en_demux(en_b), .clr(clr), .i_demux(din),
        .select(sel_b), .byte_en(be), .o_demux(ob), .o_valid(vb), .o_err(eb)
    );

    param_demux_reg #(.input_length(32), .X_to_1(5), .ZERO_REG(1)) dut_c (
        .clk(clk), .rst(rst), .en_demux(en_c), .clr(clr), .i_demux(din),
        .select(sel_c), .byte_en(be), .o_demux(oc), .o_valid(vc), .o_err(ec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic c, input logic [4:0] s,
                                 input logic [31:0] d, input logic [3:0] b);
        en_a  = en;
        clr   = c;
        sel_a = s;
        din   = d;
        be    = b;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;

        vecs[0]  = '{1'b1, 1'b0, 5'd7,  32'h12345678, 4'hF, 7,  32'h12345678, 32'h0000_0080, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 5'd7,  32'h00000000, 4'hF, 7,  32'h12345678, 32'h0000_0000, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 5'd3,  32'hAABBCCDD, 4'hF, 3,  32'hAABBCCDD, 32'h0000_0008, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 5'd3,  32'h11223344, 4'h5, 3,  32'hAA22CC44, 32'h0000_0008, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 5'd0,  32'hFFFFFFFF, 4'hF, 0,  32'h00000000, 32'h0000_0000, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 5'd0,  32'hFFFFFFFF, 4'hF, 0,  32'h00000000, 32'h0000_0000, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 5'd3,  32'hFFFFFFFF, 4'h0, 3,  32'hAA22CC44, 32'h0000_0008, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 5'd31, 32'h99000000, 4'h8, 31, 32'h99000000, 32'h8000_0000, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 5'd31, 32'h000000AB, 4'h1, 31, 32'h990000AB, 32'h8000_0000, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 5'd0,  32'h00000000, 4'h0, 7,  32'h12345678, 32'h0000_0000, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 5'd2,  32'h00000055, 4'hF, 7,  32'h00000000, 32'h0000_0000, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 5'd0,  32'h00000000, 4'h0, 3,  32'h00000000, 32'h0000_0000, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 5'd2,  32'h00000001, 4'hF, 2,  32'h00000001, 32'h0000_0004, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 5'd2,  32'h00000002, 4'hF, 2,  32'h00000002, 32'h0000_0004, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 5'd2,  32'h00000000, 4'hF, 2,  32'h00000002, 32'h0000_0000, 1'b0};

        rst = 1'b1; clr = 1'b0; din = '0; be = '0;
        en_a = 1'b0; sel_a = '0;
        en_b = 1'b0; sel_b = '0;
        en_c = 1'b0; sel_c = '0;

        $display("[TB] reset state");
        repeat (2) tick();
        checkOutput("rst_oa5", oa[5], 32'h0);
        checkOutput("rst_va", va, 32'h0);
        checkOutput("rst_ea", {31'h0, ea}, 32'h0);
        checkOutput("rst_ob0", ob[0], 32'h0);
        checkOutput("rst_vc", {27'h0, vc}, 32'h0);
        checkOutput("rst_ec", {31'h0, ec}, 32'h0);
        rst = 1'b0;

        $display("[TB] vector table on default instance");
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].en, vecs[i].clr, vecs[i].sel, vecs[i].din, vecs[i].be);
            checkOutput($sformatf("vec%0d_word", i), oa[vecs[i].idx], vecs[i].exp_word);
            checkOutput($sformatf("vec%0d_valid", i), va, vecs[i].exp_valid);
            checkOutput($sformatf("vec%0d_err", i), {31'h0, ea}, {31'h0, vecs[i].exp_err});
            if (i == 0) begin
                checkOutput("vec0_neighbor6", oa[6], 32'h0);
                checkOutput("vec0_neighbor8", oa[8], 32'h0);
            end
        end
        checkOutput("zero_reg_const", oa[0], 32'h0);
        checkOutput("reg31_after_clr", oa[31], 32'h0);

        $display("[TB] writable register 0");
        en_a = 1'b0;
        en_b = 1'b1; sel_b = 5'd0; din = 32'hFFFFFFFF; be = 4'hF;
        tick();
        checkOutput("zr0_word", ob[0], 32'hFFFFFFFF);
        checkOutput("zr0_valid", vb, 32'h0000_0001);
        checkOutput("zr0_err", {31'h0, eb}, 32'h0);
        en_b = 1'b0;
        tick();
        checkOutput("zr0_valid_drop", vb, 32'h0);
        checkOutput("zr0_hold", ob[0], 32'hFFFFFFFF);

        $display("[TB] five-register instance range check");
        en_c = 1'b1; sel_c = 3'd6; din = 32'h00000001; be = 4'hF;
        tick();
        checkOutput("oor6_err", {31'h0, ec}, 32'h1);
        checkOutput("oor6_valid", {27'h0, vc}, 32'h0);
        checkOutput("oor6_reg4", oc[4], 32'h0);
        checkOutput("oor6_reg1", oc[1], 32'h0);
        sel_c = 3'd4;
        tick();
        checkOutput("sel4_word", oc[4], 32'h1);
        checkOutput("sel4_valid", {27'h0, vc}, 32'h10);
        checkOutput("sel4_err", {31'h0, ec}, 32'h0);
        sel_c = 3'd5; din = 32'hFFFFFFFF;
        tick();
        checkOutput("oor5_err", {31'h0, ec}, 32'h1);
        checkOutput("oor5_reg4", oc[4], 32'h1);
        en_c = 1'b0;
        tick();
        checkOutput("idle_err", {31'h0, ec}, 32'h0);
        checkOutput("idle_valid", {27'h0, vc}, 32'h0);

        $display("[TB] asynchronous reset mid-operation");
        applyStimulus(1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 4'hF);
        checkOutput("pre_rst_word", oa[5], 32'hDEADBEEF);
        checkOutput("pre_rst_valid", va, 32'h0000_0020);
        en_a = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_word", oa[5], 32'h0);
        checkOutput("async_rst_valid", va, 32'h0);
        checkOutput("async_rst_err", {31'h0, ea}, 32'h0);
        checkOutput("async_rst_ob0", ob[0], 32'h0);
        en_a = 1'b1; sel_a = 5'd9; din = 32'hCAFEF00D; be = 4'hF;
        tick();
        checkOutput("rst_blocks_write", oa[9], 32'h0);
        checkOutput("rst_blocks_valid", va, 32'h0);
        rst = 1'b0;
        tick();
        checkOutput("post_rst_word", oa[9], 32'hCAFEF00D);
        checkOutput("post_rst_valid", va, 32'h0000_0200);
        en_a = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/param_demux_reg.md
Name: param_demux_reg

Overview:
- Parameterised 1-to-X registered demultiplexer with storage. It is the write-side counterpart of the param_mux read path.
- Each accepted write routes one input word to one of X storage registers, under byte-lane control.
- All X registers are exposed as an array, so param_mux instances can read them. Typical use: register-file write port, CSR bank.
- Writes are single-cycle and registered. A one-hot valid pulse marks the register updated each cycle.

Parameters:
- input_length, 32: word width in bits; must be a multiple of 8.
- X_to_1, 32: number of storage registers / demux outputs; must be >= 2.
- ZERO_REG, 1: 1 = register 0 is hardwired to zero and ignores writes; 0 = register 0 is writable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en_demux  input  1  write request; sampled on rising clk
- clr  input  1  synchronous clear of all registers
- i_demux  input  input_length  write data
- select  input  $clog2(X_to_1)  destination register index
- byte_en  input  input_length/8  per-byte write strobes; bit k covers bits [8k+7:8k]
- o_demux  output  input_length x X_to_1 (unpacked array)  stored register contents
- o_valid  output  X_to_1  one-hot pulse; bit i high for one cycle when register i was written on the previous edge
- o_err  output  1  one-cycle pulse: the previous request was rejected

Behaviour:
- Reset:
  - rst high drives every o_demux[i] = 0, o_valid = 0 and o_err = 0 immediately, independent of clk.
  - Deassertion is taken on the next rising clk; no write is accepted on an edge where rst is high.
- Priority at each rising edge: rst > clr > write.
- clr=1:
  - All o_demux[i] become 0 and o_valid becomes 0, whatever en_demux is.
  - o_err is 0 that cycle; a simultaneous write is dropped silently.
- Accepted write, when en_demux=1, clr=0, select < X_to_1, and not (ZERO_REG=1 and select=0):
  - For each k with byte_en[k]=1, o_demux[select][8k+7:8k] takes i_demux[8k+7:8k].
  - Bytes with byte_en[k]=0 are unchanged.
  - All other registers hold.
  - o_valid = one-hot(select) for exactly the next cycle.
- byte_en all zero with a valid select:
  - The write is still accepted; o_valid pulses.
  - No data changes.
- Rejected request, when en_demux=1 and either select >= X_to_1 (non-power-of-two X_to_1) or ZERO_REG=1 with select=0:
  - No register changes; o_valid = 0.
  - o_err = 1 for the next cycle.
- en_demux=0: all registers hold; o_valid = 0; o_err = 0.
- Latency:
  - New data is visible on o_demux in the cycle after the sampling edge.
  - o_valid and o_err assert in the same cycle as the data update.
- Back-to-back writes are accepted every cycle, including repeated writes to the same index. o_valid then stays high on that bit for consecutive cycles.
- ZERO_REG=1: o_demux[0] is constant 0 in all states, and o_valid[0] never asserts.
- Implementation structure:
  - Per-register byte-lane write enables decoded from select, en_demux and byte_en.
  - Storage flops for X_to_1 words.
  - Registered o_valid / o_err pulse flops.
- No combinational path from inputs to outputs.

Test Plan:
- Reset mid-operation: load reg 5 = 0xDEADBEEF, then assert rst between clock edges -> o_demux[5]=0 immediately; o_valid=0; o_err=0.
- Full write, defaults: en_demux=1, select=7, byte_en=4'b1111, i_demux=0x12345678 -> next cycle o_demux[7]=0x12345678, o_valid=32'h0000_0080 for one cycle; other registers unchanged.
- Byte strobes: reg 3 = 0xAABBCCDD, then write 0x11223344 with byte_en=4'b0101 -> o_demux[3]=0xAA22CC44; o_valid[3] pulses.
- Zero register:
  - ZERO_REG=1: write 0xFFFFFFFF to select=0 -> o_demux[0]=0, o_valid=0, o_err=1 for one cycle.
  - ZERO_REG=0: the same write -> o_demux[0]=0xFFFFFFFF, o_valid[0]=1.
- Out-of-range index: X_to_1=5, select=6, en_demux=1 -> no register changes; o_err=1 one cycle. Then select=4 write 0x1 -> o_demux[4]=1, o_valid=5'b10000.
- Clear vs write: registers loaded, then clr=1 with en_demux=1, select=2, data 0x55 -> all o_demux=0, o_valid=0, o_err=0. Back-to-back writes to select=2 of 0x1 then 0x2 -> o_valid[2] high two consecutive cycles; final o_demux[2]=0x2.
